// File: rtl/bp_npc_gen_pkg.sv
// Shared constants and state encoding for the fetch-stage next-PC generator.
// Imported by the generator top and its saturating perf counters.
package bp_npc_gen_pkg;

    localparam int unsigned PC_WIDTH_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h1c00_0000;
    localparam int unsigned INST_BYTES_DEF = 4;
    localparam int unsigned INST_ALIGN_DEF = $clog2(INST_BYTES_DEF);
    localparam int unsigned CNT_WIDTH_DEF  = 32;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Low-address mask that must be zero for a target to be instruction aligned.
    function automatic logic [31:0] align_mask(input int unsigned align_bits);
        return (32'd1 << align_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating event counter: counts single-cycle increment strobes and sticks
// at all-ones instead of wrapping.
module bp_sat_counter
    import bp_npc_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bp_npc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC, drives the BTB lookup PC,
// picks BTB target / sequential PC / execute redirect, and hands off to decode.
module bp_npc_gen
    import bp_npc_gen_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEF),
    parameter int unsigned         INST_BYTES = INST_BYTES_DEF,
    parameter int unsigned         CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,

    output logic [PC_WIDTH-1:0]  btb_pc_o,
    input  logic                 btb_hit_i,
    input  logic [PC_WIDTH-1:0]  btb_target_i,

    input  logic                 ex_redirect_valid_i,
    input  logic [PC_WIDTH-1:0]  ex_redirect_pc_i,

    input  logic                 id_allowin_i,
    output logic                 if_valid_o,
    output logic [PC_WIDTH-1:0]  if_pc_o,
    output logic                 if_pred_taken_o,
    output logic [PC_WIDTH-1:0]  if_pred_target_o,

    output logic [CNT_WIDTH-1:0] perf_fetch_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_taken_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_redirect_cnt_o
);

    localparam int unsigned         ALIGN_BITS = $clog2(INST_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(align_mask(ALIGN_BITS));
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INST_BYTES);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PC_WIDTH-1:0] r_f_pc;
    logic [PC_WIDTH-1:0] w_f_pc_nxt;

    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_pred_npc;
    logic                w_hit_eff;
    logic                w_if_valid;
    logic                w_handshake;
    logic                w_taken_inc;

    // The BTB result is only trusted in S_RUN; in S_INIT it belongs to a
    // lookup issued before reset or before a redirect and must be ignored.
    always_comb begin
        w_seq_pc    = r_f_pc + PC_STEP;
        w_hit_eff   = btb_hit_i && (r_state == S_RUN)
                      && ((btb_target_i & ALIGN_MASK) == '0);
        w_pred_npc  = w_hit_eff ? btb_target_i : w_seq_pc;
        w_if_valid  = (r_state == S_RUN) && !ex_redirect_valid_i;
        w_handshake = w_if_valid && id_allowin_i;
        w_taken_inc = w_handshake && w_hit_eff;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_f_pc_nxt  = r_f_pc;
        btb_pc_o    = r_f_pc;
        case (r_state)
            S_INIT: begin
                if (ex_redirect_valid_i) begin
                    w_f_pc_nxt = ex_redirect_pc_i;
                    btb_pc_o   = ex_redirect_pc_i;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (ex_redirect_valid_i) begin
                    w_f_pc_nxt = ex_redirect_pc_i;
                    btb_pc_o   = ex_redirect_pc_i;
                end else if (w_handshake) begin
                    w_f_pc_nxt = w_pred_npc;
                    btb_pc_o   = w_pred_npc;
                end
                // Stall: re-present f_pc so next cycle's BTB result still matches it.
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
        if (reset) begin
            btb_pc_o = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_f_pc  <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_f_pc  <= w_f_pc_nxt;
        end
    end

    assign if_valid_o       = w_if_valid;
    assign if_pc_o          = r_f_pc;
    assign if_pred_taken_o  = w_hit_eff;
    assign if_pred_target_o = w_pred_npc;

    bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_handshake),
        .o_cnt (perf_fetch_cnt_o)
    );

    bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_taken_inc),
        .o_cnt (perf_taken_cnt_o)
    );

    bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (ex_redirect_valid_i),
        .o_cnt (perf_redirect_cnt_o)
    );

endmodule

// File: tb/tb_bp_npc_gen.sv
// Bench for bp_npc_gen: directed scenarios plus randomized traffic, checked
// against a fetch-stage reference model; a 3-bit-counter copy shows saturation.
module tb_bp_npc_gen;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        btb_hit_i;
    logic [31:0] btb_target_i;
    logic        ex_redirect_valid_i;
    logic [31:0] ex_redirect_pc_i;
    logic        id_allowin_i;

    logic [31:0] btb_pc_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic        if_pred_taken_o;
    logic [31:0] if_pred_target_o;
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_taken_cnt_o;
    logic [31:0] perf_redirect_cnt_o;

    logic [31:0] s_btb_pc;
    logic        s_if_valid;
    logic [31:0] s_if_pc;
    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic [2:0]  s_fetch_cnt;
    logic [2:0]  s_taken_cnt;
    logic [2:0]  s_redirect_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_run;
    int unsigned m_fetch, m_taken, m_redir;
    // Expected outputs for the cycle currently being driven
    bit          e_valid, e_taken;
    logic [31:0] e_pc, e_target, e_btb;

    always #5 clk = ~clk;

    bp_npc_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .btb_pc_o            (btb_pc_o),
        .btb_hit_i           (btb_hit_i),
        .btb_target_i        (btb_target_i),
        .ex_redirect_valid_i (ex_redirect_valid_i),
        .ex_redirect_pc_i    (ex_redirect_pc_i),
        .id_allowin_i        (id_allowin_i),
        .if_valid_o          (if_valid_o),
        .if_pc_o             (if_pc_o),
        .if_pred_taken_o     (if_pred_taken_o),
        .if_pred_target_o    (if_pred_target_o),
        .perf_fetch_cnt_o    (perf_fetch_cnt_o),
        .perf_taken_cnt_o    (perf_taken_cnt_o),
        .perf_redirect_cnt_o (perf_redirect_cnt_o)
    );

    bp_npc_gen #(.CNT_WIDTH(3)) dut_s (
        .clk                 (clk),
        .reset               (reset),
        .btb_pc_o            (s_btb_pc),
        .btb_hit_i           (btb_hit_i),
        .btb_target_i        (btb_target_i),
        .ex_redirect_valid_i (ex_redirect_valid_i),
        .ex_redirect_pc_i    (ex_redirect_pc_i),
        .id_allowin_i        (id_allowin_i),
        .if_valid_o          (s_if_valid),
        .if_pc_o             (s_if_pc),
        .if_pred_taken_o     (s_pred_taken),
        .if_pred_target_o    (s_pred_target),
        .perf_fetch_cnt_o    (s_fetch_cnt),
        .perf_taken_cnt_o    (s_taken_cnt),
        .perf_redirect_cnt_o (s_redirect_cnt)
    );

    function automatic logic [2:0] sat3(input int unsigned v);
        return (v > 7) ? 3'd7 : v[2:0];
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_run = 0; m_fetch = 0; m_taken = 0; m_redir = 0;
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and derive expectations.
    task automatic set_in(input bit hit, input logic [31:0] tgt, input bit rv,
                          input logic [31:0] rpc, input bit allow);
        btb_hit_i = hit; btb_target_i = tgt;
        ex_redirect_valid_i = rv; ex_redirect_pc_i = rpc; id_allowin_i = allow;
        e_pc     = m_pc;
        e_valid  = m_run && !rv;
        e_taken  = m_run && hit && (tgt[1:0] == 2'b00);
        e_target = e_taken ? tgt : m_pc + 32'd4;
        if (rv)                   e_btb = rpc;
        else if (e_valid && allow) e_btb = e_target;
        else                      e_btb = m_pc;
        #1;
    endtask

    // Advance one clock and apply the fetch-stage rules to the model.
    task automatic tick();
        @(posedge clk);
        if (ex_redirect_valid_i) begin
            m_pc = ex_redirect_pc_i;
            m_redir++;
        end else if (!m_run) begin
            m_run = 1;
        end else if (id_allowin_i) begin
            m_pc = e_target;
            m_fetch++;
            if (e_taken) m_taken++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; btb_hit_i = 1; btb_target_i = 32'h1c00_0040;
        ex_redirect_valid_i = 0; ex_redirect_pc_i = 0; id_allowin_i = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid_o); end
        checks++; if (if_pc_o !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", if_pc_o, RST_PC); end
        checks++; if (btb_pc_o !== RST_PC) begin errors++; $display("FAIL rst_btb_pc: got %h want %h", btb_pc_o, RST_PC); end
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b want 0", if_pred_taken_o); end
        checks++; if (if_pred_target_o !== 32'h1c00_0004) begin errors++; $display("FAIL rst_target: got %h want 1c000004", if_pred_target_o); end
        checks++; if ({perf_fetch_cnt_o, perf_taken_cnt_o, perf_redirect_cnt_o} !== 96'd0) begin
            errors++; $display("FAIL rst_cnt: got %h/%h/%h want 0/0/0", perf_fetch_cnt_o, perf_taken_cnt_o, perf_redirect_cnt_o); end
        reset = 0;
        model_reset();
    endtask

    task automatic test_sequential();
        set_in(0, 32'h0, 0, 32'h0, 1);
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL init_valid: got %b want 0", if_valid_o); end
        checks++; if (btb_pc_o !== 32'h1c00_0000) begin errors++; $display("FAIL init_btb_pc: got %h want 1c000000", btb_pc_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 32'h0, 0, 32'h0, 1);
            checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", k, if_valid_o); end
            checks++; if (if_pc_o !== 32'h1c00_0000 + 32'(4 * k)) begin
                errors++; $display("FAIL seq_pc%0d: got %h want %h", k, if_pc_o, 32'h1c00_0000 + 32'(4 * k)); end
            checks++; if (btb_pc_o !== 32'h1c00_0004 + 32'(4 * k)) begin
                errors++; $display("FAIL seq_btb_pc%0d: got %h want %h", k, btb_pc_o, 32'h1c00_0004 + 32'(4 * k)); end
            tick();
        end
    endtask

    task automatic test_btb_hit();
        set_in(1, 32'h1c00_0100, 0, 32'h0, 1);
        checks++; if (if_pc_o !== 32'h1c00_0008) begin errors++; $display("FAIL hit_pc: got %h want 1c000008", if_pc_o); end
        checks++; if (if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL hit_taken: got %b want 1", if_pred_taken_o); end
        checks++; if (if_pred_target_o !== 32'h1c00_0100) begin errors++; $display("FAIL hit_target: got %h want 1c000100", if_pred_target_o); end
        tick();
        checks++; if (if_pc_o !== 32'h1c00_0100) begin errors++; $display("FAIL hit_next_pc: got %h want 1c000100", if_pc_o); end
        checks++; if (perf_taken_cnt_o !== 32'd1) begin errors++; $display("FAIL hit_taken_cnt: got %0d want 1", perf_taken_cnt_o); end
    endtask

    task automatic test_misaligned();
        set_in(0, 32'h0, 1, 32'h1c00_0008, 1);
        tick();
        set_in(1, 32'h1c00_0102, 0, 32'h0, 1);
        checks++; if (if_pc_o !== 32'h1c00_0008) begin errors++; $display("FAIL mis_pc: got %h want 1c000008", if_pc_o); end
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL mis_taken: got %b want 0", if_pred_taken_o); end
        checks++; if (if_pred_target_o !== 32'h1c00_000c) begin errors++; $display("FAIL mis_target: got %h want 1c00000c", if_pred_target_o); end
        tick();
        set_in(0, 32'h0, 0, 32'h0, 1);
        checks++; if (if_pc_o !== 32'h1c00_000c) begin errors++; $display("FAIL mis_next_pc: got %h want 1c00000c", if_pc_o); end
        tick();
    endtask

    task automatic test_stall();
        int unsigned f0;
        f0 = m_fetch;
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h1c00_0200, 0, 32'h0, 0);
            checks++; if (if_pc_o !== 32'h1c00_0010 || btb_pc_o !== 32'h1c00_0010) begin
                errors++; $display("FAIL stall_pc%0d: got pc %h btb %h want 1c000010", k, if_pc_o, btb_pc_o); end
            checks++; if (if_pred_taken_o !== 1'b1 || if_pred_target_o !== 32'h1c00_0200) begin
                errors++; $display("FAIL stall_pred%0d: got %b/%h want 1/1c000200", k, if_pred_taken_o, if_pred_target_o); end
            checks++; if (perf_fetch_cnt_o !== f0) begin errors++; $display("FAIL stall_cnt%0d: got %0d want %0d", k, perf_fetch_cnt_o, f0); end
            tick();
        end
        set_in(1, 32'h1c00_0200, 0, 32'h0, 1);
        checks++; if (btb_pc_o !== 32'h1c00_0200) begin errors++; $display("FAIL stall_rel_btb: got %h want 1c000200", btb_pc_o); end
        tick();
        checks++; if (if_pc_o !== 32'h1c00_0200) begin errors++; $display("FAIL stall_rel_pc: got %h want 1c000200", if_pc_o); end
        checks++; if (perf_fetch_cnt_o !== f0 + 1) begin errors++; $display("FAIL stall_rel_cnt: got %0d want %0d", perf_fetch_cnt_o, f0 + 1); end
    endtask

    task automatic test_redirect();
        int unsigned r0;
        r0 = m_redir;
        set_in(1, 32'h1c00_0300, 1, 32'h1c00_0400, 0);
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", if_valid_o); end
        checks++; if (btb_pc_o !== 32'h1c00_0400) begin errors++; $display("FAIL redir_btb: got %h want 1c000400", btb_pc_o); end
        tick();
        set_in(0, 32'h0, 0, 32'h0, 1);
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h1c00_0400) begin
            errors++; $display("FAIL redir_next: got %b/%h want 1/1c000400", if_valid_o, if_pc_o); end
        checks++; if (perf_redirect_cnt_o !== r0 + 1) begin errors++; $display("FAIL redir_cnt: got %0d want %0d", perf_redirect_cnt_o, r0 + 1); end
        tick();
    endtask

    task automatic test_wrap();
        set_in(0, 32'h0, 1, 32'hffff_fffc, 1);
        tick();
        set_in(0, 32'h0, 0, 32'h0, 1);
        checks++; if (if_pc_o !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc_o); end
        checks++; if (if_pred_target_o !== 32'h0 || btb_pc_o !== 32'h0) begin
            errors++; $display("FAIL wrap_npc: got %h/%h want 0/0", if_pred_target_o, btb_pc_o); end
        tick();
        checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", if_pc_o); end
    endtask

    task automatic test_random(input int n);
        bit          hit, rv, allow;
        logic [31:0] tgt, rpc;
        for (int i = 0; i < n; i++) begin
            hit   = ($urandom_range(0, 2) == 0);
            tgt   = $urandom;
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            rv    = ($urandom_range(0, 9) == 0);
            rpc   = $urandom & 32'hffff_fffc;
            allow = ($urandom_range(0, 3) != 0);
            set_in(hit, tgt, rv, rpc, allow);
            checks++; if (if_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, if_valid_o, e_valid); end
            checks++; if (if_pc_o !== e_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", i, if_pc_o, e_pc); end
            checks++; if (if_pred_taken_o !== e_taken) begin errors++; $display("FAIL rnd_taken@%0d: got %b want %b", i, if_pred_taken_o, e_taken); end
            checks++; if (if_pred_target_o !== e_target) begin errors++; $display("FAIL rnd_target@%0d: got %h want %h", i, if_pred_target_o, e_target); end
            checks++; if (btb_pc_o !== e_btb) begin errors++; $display("FAIL rnd_btb_pc@%0d: got %h want %h", i, btb_pc_o, e_btb); end
            checks++; if (perf_fetch_cnt_o !== m_fetch) begin errors++; $display("FAIL rnd_fetch_cnt@%0d: got %0d want %0d", i, perf_fetch_cnt_o, m_fetch); end
            checks++; if (perf_taken_cnt_o !== m_taken) begin errors++; $display("FAIL rnd_taken_cnt@%0d: got %0d want %0d", i, perf_taken_cnt_o, m_taken); end
            checks++; if (perf_redirect_cnt_o !== m_redir) begin errors++; $display("FAIL rnd_redir_cnt@%0d: got %0d want %0d", i, perf_redirect_cnt_o, m_redir); end
            checks++; if ({s_fetch_cnt, s_taken_cnt, s_redirect_cnt} !== {sat3(m_fetch), sat3(m_taken), sat3(m_redir)}) begin
                errors++; $display("FAIL rnd_small_cnt@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, s_fetch_cnt, s_taken_cnt,
                                   s_redirect_cnt, sat3(m_fetch), sat3(m_taken), sat3(m_redir)); end
            checks++; if ({s_btb_pc, s_if_valid, s_if_pc, s_pred_taken, s_pred_target} !== {e_btb, e_valid, e_pc, e_taken, e_target}) begin
                errors++; $display("FAIL rnd_small_out@%0d: got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", i, s_btb_pc, s_if_valid, s_if_pc,
                                   s_pred_taken, s_pred_target, e_btb, e_valid, e_pc, e_taken, e_target); end
            tick();
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h1c00_1000, 0, 32'h0, 1);
            tick();
        end
        checks++; if (s_fetch_cnt !== 3'd7 || s_taken_cnt !== 3'd7 || s_redirect_cnt !== 3'd7) begin
            errors++; $display("FAIL sat_hold: got %0d/%0d/%0d want 7/7/7", s_fetch_cnt, s_taken_cnt, s_redirect_cnt); end
        checks++; if (perf_fetch_cnt_o !== m_fetch || perf_taken_cnt_o !== m_taken) begin
            errors++; $display("FAIL sat_wide: got %0d/%0d want %0d/%0d", perf_fetch_cnt_o, perf_taken_cnt_o, m_fetch, m_taken); end
    endtask

    task automatic test_reset_midrun();
        reset = 1; btb_hit_i = 1; btb_target_i = 32'h1c00_0800;
        ex_redirect_valid_i = 0; id_allowin_i = 1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (if_pc_o !== RST_PC || btb_pc_o !== RST_PC || if_valid_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out: got %h/%h/%b want %h/%h/0", if_pc_o, btb_pc_o, if_valid_o, RST_PC, RST_PC); end
        checks++; if ({perf_fetch_cnt_o, perf_taken_cnt_o, perf_redirect_cnt_o} !== 96'd0) begin
            errors++; $display("FAIL mid_rst_cnt: got %0d/%0d/%0d want 0/0/0", perf_fetch_cnt_o, perf_taken_cnt_o, perf_redirect_cnt_o); end
        reset = 0;
        model_reset();
        set_in(1, 32'h1c00_0800, 0, 32'h0, 1);
        checks++; if (if_valid_o !== 1'b0 || if_pred_taken_o !== 1'b0 || btb_pc_o !== RST_PC) begin
            errors++; $display("FAIL mid_init: got %b/%b/%h want 0/0/%h", if_valid_o, if_pred_taken_o, btb_pc_o, RST_PC); end
        tick();
        set_in(0, 32'h0, 0, 32'h0, 1);
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== RST_PC) begin
            errors++; $display("FAIL mid_first: got %b/%h want 1/%h", if_valid_o, if_pc_o, RST_PC); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_btb_hit();
        test_misaligned();
        test_stall();
        test_redirect();
        test_wrap();
        test_random(400);
        test_saturation();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_npc_gen.md
Name: bp_npc_gen

Overview:
- Next-PC generator for the instruction-fetch stage, sitting directly downstream of the branch target buffer (BTB).
- Each cycle it drives the lookup PC into the BTB and holds the current fetch PC.
- One cycle later it consumes the BTB's registered hit/target result and chooses the next PC: BTB target, sequential PC, or execute-stage redirect.
- It presents the fetch PC plus prediction to decode through a valid/allowin handshake and keeps saturating prediction statistics.

Parameters:
- PC_WIDTH, 32, width of all PCs and targets.
- RESET_PC, 32'h1c000000, first fetch address after reset.
- INST_BYTES, 4, sequential increment; must be a power of two.
- CNT_WIDTH, 32, width of the perf counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- btb_pc_o  out  PC_WIDTH  lookup PC driven into the BTB this cycle; the result is visible next cycle.
- btb_hit_i  in  1  BTB hit for the PC presented on the previous cycle.
- btb_target_i  in  PC_WIDTH  BTB predicted target, qualified by btb_hit_i.
- ex_redirect_valid_i  in  1  execute-stage mispredict/redirect strobe.
- ex_redirect_pc_i  in  PC_WIDTH  correct PC on redirect.
- id_allowin_i  in  1  decode can accept this cycle.
- if_valid_o  out  1  fetch-stage output valid.
- if_pc_o  out  PC_WIDTH  current fetch PC.
- if_pred_taken_o  out  1  predicted taken for if_pc_o.
- if_pred_target_o  out  PC_WIDTH  predicted next PC for if_pc_o.
- perf_fetch_cnt_o  out  CNT_WIDTH  accepted fetches, saturating.
- perf_taken_cnt_o  out  CNT_WIDTH  accepted predicted-taken fetches, saturating.
- perf_redirect_cnt_o  out  CNT_WIDTH  redirects, saturating.

Behaviour:
- Registers:
  - f_pc: fetch PC, reset RESET_PC.
  - state: S_INIT or S_RUN, reset S_INIT.
  - Three perf counters, reset 0.
- Reset values of outputs:
  - if_valid_o=0, if_pc_o=RESET_PC, btb_pc_o=RESET_PC.
  - if_pred_taken_o=0, if_pred_target_o=RESET_PC+INST_BYTES.
- S_INIT (one cycle after reset deasserts):
  - btb_pc_o=f_pc; if_valid_o=0; go to S_RUN.
  - If ex_redirect_valid_i is high: f_pc<=ex_redirect_pc_i, btb_pc_o=ex_redirect_pc_i, stay in S_INIT.
- Effective hit:
  - hit_eff = btb_hit_i && state==S_RUN && btb_target_i[log2(INST_BYTES)-1:0]==0.
  - A misaligned target is treated as a miss.
- Prediction:
  - pred_npc = hit_eff ? btb_target_i : f_pc+INST_BYTES, truncated to PC_WIDTH (wraps modulo 2^PC_WIDTH).
  - if_pred_taken_o=hit_eff; if_pred_target_o=pred_npc.
- S_RUN, priority order:
  1. Redirect:
     - btb_pc_o=ex_redirect_pc_i, f_pc<=ex_redirect_pc_i.
     - if_valid_o=0 that cycle (wrong-path fetch killed, no handshake).
     - Redirect wins over stall.
  2. Handshake (if_valid_o && id_allowin_i): btb_pc_o=pred_npc, f_pc<=pred_npc.
  3. Stall (!id_allowin_i): btb_pc_o=f_pc, f_pc holds. Re-presenting f_pc keeps the BTB result valid for every stalled cycle.
- if_valid_o = state==S_RUN && !ex_redirect_valid_i. Outputs for the fetch PC are combinational from f_pc and the BTB result.
- Latency:
  - Sequential or predicted-taken stream is one fetch per cycle with zero bubbles.
  - A redirect costs exactly one invalid cycle; the redirect target is valid the next cycle.
- BTB write in the same cycle as a read of the same index: the old data is used; no forwarding.
- Perf counters increment by 1 on the following events and hold at all-ones:
  - perf_fetch_cnt_o: each handshake.
  - perf_taken_cnt_o: each handshake with hit_eff.
  - perf_redirect_cnt_o: each ex_redirect_valid_i cycle.
- Reset mid-operation: all state returns to reset values next edge; an in-flight BTB result is ignored via S_INIT.
- btb_pc_o must never be X; it is driven in every state.

Decomposition:
- Shared package holds:
  - PC_WIDTH and RESET_PC defaults.
  - State encoding S_INIT=1'b0, S_RUN=1'b1.
  - INST_BYTES together with its log2 as an alignment constant.
- One natural sub-module: bp_sat_counter (CNT_WIDTH, inc, saturating), instantiated three times.
- The next-PC mux stays inline.

Test Plan:
- Reset then release, BTB miss, allowin=1.
  - Expected: if_valid_o=0 for one cycle.
  - Then if_pc_o = 1c000000, 1c000004, 1c000008, …; btb_pc_o is one step ahead of if_pc_o.
- BTB hit at f_pc=1c000008, target 1c000100, allowin=1.
  - Expected: if_pred_taken_o=1, next cycle if_pc_o=1c000100, perf_taken_cnt_o=1.
- Hit with target 1c000102 (misaligned).
  - Expected: if_pred_taken_o=0, next if_pc_o=1c00000c.
- Stall for 3 cycles at f_pc=1c000010 with BTB hit to 1c000200.
  - Expected: if_pc_o and btb_pc_o hold 1c000010 and the prediction stays stable.
  - Release: if_pc_o=1c000200; perf_fetch_cnt_o counts 1 for the stalled instruction.
- ex_redirect_valid_i=1 with pc 1c000400, simultaneous with a stall and a BTB hit.
  - Expected: if_valid_o=0 that cycle, btb_pc_o=1c000400, next cycle if_pc_o=1c000400 valid, perf_redirect_cnt_o incremented.
- f_pc=ffff_fffc, miss → next if_pc_o=0000_0000.
- Counter preloaded at all-ones → holds all-ones after another handshake.
